// File: rtl/sparc_pkg.sv
// rtl/sparc_pkg.sv - shared constants, widths and FSM state type for the fetch stage
package sparc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_INST_WIDTH = 32;
  localparam int STALL_CNT_WIDTH    = 32;

  // Word presented to decode whenever no fetched instruction is held
  localparam logic [31:0] NOP_INST = 32'h0100_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stall_counter.sv
// rtl/if_stall_counter.sv - saturating decode-stall cycle counter
// Instantiated by instruction_fetch only when IF_PERF_CNT_EN is defined.
module if_stall_counter
  import sparc_pkg::*;
#(
  parameter int CNT_WIDTH = STALL_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch with branch redirect
// Optional stall counter enabled by macro IF_PERF_CNT_EN.
module instruction_fetch
  import sparc_pkg::*;
#(
  parameter int                        BUS_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                        BUS_INST_WIDTH = DEFAULT_INST_WIDTH,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       im_req_valid,
  output logic [BUS_DATA_WIDTH-1:0]  im_req_addr,
  input  logic                       im_req_ready,
  input  logic                       im_resp_valid,
  input  logic [BUS_INST_WIDTH-1:0]  im_resp_data,
  output logic [BUS_INST_WIDTH-1:0]  inst,
  output logic [BUS_DATA_WIDTH-1:0]  IF_PCplus4_out,
  input  logic                       id_ready,
  input  logic                       br_taken,
  input  logic [BUS_DATA_WIDTH-1:0]  br_target,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [BUS_INST_WIDTH-1:0] NOP = BUS_INST_WIDTH'(NOP_INST);

  if_state_e                 state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_DATA_WIDTH-1:0] pcp4_q, pcp4_d;
  logic [BUS_INST_WIDTH-1:0] ir_q, ir_d;
  logic                      squash_q, squash_d;
  logic                      live_q;
  logic [BUS_DATA_WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + BUS_DATA_WIDTH'(4);

  // live_q keeps the request low until the first edge after reset release
  assign im_req_valid   = (state_q == FETCH) && live_q;
  assign im_req_addr    = pc_q;
  assign inst           = (state_q == HOLD) ? ir_q : NOP;
  assign IF_PCplus4_out = pcp4_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pcp4_d   = pcp4_q;
    ir_d     = ir_q;
    squash_d = squash_q;
    unique case (state_q)
      FETCH: begin
        if (br_taken) begin
          pc_d = br_target;
        end else if (im_req_valid && im_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (br_taken) begin
          // A response in the same cycle is the stale one; otherwise drop the next
          pc_d = br_target;
          if (im_resp_valid) begin
            state_d  = FETCH;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (im_resp_valid) begin
          if (squash_q) begin
            state_d  = FETCH;
            squash_d = 1'b0;
          end else begin
            ir_d    = im_resp_data;
            pcp4_d  = pc_plus4;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_d    = br_target;
          ir_d    = NOP;
          state_d = FETCH;
        end else if (id_ready) begin
          pc_d    = pc_plus4;
          ir_d    = NOP;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      pcp4_q   <= '0;
      ir_q     <= NOP;
      squash_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pcp4_q   <= pcp4_d;
      ir_q     <= ir_d;
      squash_q <= squash_d;
      live_q   <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic stall_en;

  assign stall_en = (state_q == HOLD) && !id_ready;

  if_stall_counter #(
    .CNT_WIDTH(STALL_CNT_WIDTH)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .cnt   (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] NOP_W = 32'h0100_0000;
`ifdef IF_PERF_CNT_EN
  localparam logic [63:0] EXP_STALL = 64'd5;
`else
  localparam logic [63:0] EXP_STALL = 64'd0;
`endif

  logic        clk;
  logic        reset;
  logic        im_req_valid;
  logic [63:0] im_req_addr;
  logic        im_req_ready;
  logic        im_resp_valid;
  logic [31:0] im_resp_data;
  logic [31:0] inst;
  logic [63:0] IF_PCplus4_out;
  logic        id_ready;
  logic        br_taken;
  logic [63:0] br_target;
  logic [31:0] stall_cnt;

  instruction_fetch #(
    .BUS_DATA_WIDTH(64),
    .BUS_INST_WIDTH(32),
    .RESET_PC      (64'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .im_req_valid  (im_req_valid),
    .im_req_addr   (im_req_addr),
    .im_req_ready  (im_req_ready),
    .im_resp_valid (im_resp_valid),
    .im_resp_data  (im_resp_data),
    .inst          (inst),
    .IF_PCplus4_out(IF_PCplus4_out),
    .id_ready      (id_ready),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_REQ_VALID, S_REQ_ADDR, S_INST, S_PCP4, S_STALL, S_REQ_Q, S_INST_Q} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [63:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [63:0] exp_req[$];
  logic [31:0] exp_inst[$];
  logic [63:0] exp_pcp4[$];

  int n_checks = 0;
  int n_fail   = 0;

  chk_t        mon_c;
  logic [63:0] mon_act;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_now(input string name, input sig_e sig, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // Monitor: drains queued point checks and scores every accepted request and handoff
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      case (mon_c.sig)
        S_REQ_VALID: mon_act = 64'(im_req_valid);
        S_REQ_ADDR:  mon_act = im_req_addr;
        S_INST:      mon_act = 64'(inst);
        S_PCP4:      mon_act = IF_PCplus4_out;
        S_STALL:     mon_act = 64'(stall_cnt);
        S_REQ_Q:     mon_act = 64'(exp_req.size());
        default:     mon_act = 64'(exp_inst.size());
      endcase
      compare(mon_c.name, mon_act, mon_c.exp);
    end
    if (reset && im_req_valid && im_req_ready && !br_taken) begin
      if (exp_req.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_request: got addr %h expected none", im_req_addr);
      end else begin
        compare("req_addr", im_req_addr, exp_req.pop_front());
      end
    end
    if (reset && (inst != NOP_W) && id_ready && !br_taken) begin
      if (exp_inst.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_handoff: got inst %h expected none", inst);
      end else begin
        compare("handoff_inst", 64'(inst), 64'(exp_inst.pop_front()));
        compare("handoff_pcp4", IF_PCplus4_out, exp_pcp4.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request accepted, response one cycle later, decode ready: full round trip
  task automatic xact(input logic [63:0] addr, input logic [31:0] data);
    exp_req.push_back(addr);
    im_req_ready = 1'b1;
    id_ready     = 1'b1;
    step();
    im_req_ready = 1'b0;
    exp_inst.push_back(data);
    exp_pcp4.push_back(addr + 64'd4);
    im_resp_valid = 1'b1;
    im_resp_data  = data;
    step();
    im_resp_valid = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    im_req_ready  = 1'b0;
    im_resp_valid = 1'b0;
    im_resp_data  = '0;
    id_ready      = 1'b0;
    br_taken      = 1'b0;
    br_target     = '0;
    #2 reset = 1'b0;

    expect_now("rst_req_valid", S_REQ_VALID, 64'd0);
    expect_now("rst_req_addr",  S_REQ_ADDR,  64'd0);
    expect_now("rst_inst",      S_INST,      64'(NOP_W));
    expect_now("rst_pcp4",      S_PCP4,      64'd0);
    expect_now("rst_stall",     S_STALL,     64'd0);
    step();
    step();
    reset = 1'b1;
    expect_now("release_req_valid", S_REQ_VALID, 64'd0);
    step();

    // Basic fetch and sequential next request
    xact(64'h0, 32'h8210_2005);
    xact(64'h4, 32'h9010_0001);

    // Decode stalls five cycles in HOLD
    exp_req.push_back(64'h8);
    im_req_ready = 1'b1;
    id_ready     = 1'b0;
    step();
    im_req_ready  = 1'b0;
    im_resp_valid = 1'b1;
    im_resp_data  = 32'hA200_0003;
    step();
    im_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_now("stall_inst",      S_INST,      64'h0000_0000_A200_0003);
      expect_now("stall_pcp4",      S_PCP4,      64'hC);
      expect_now("stall_req_valid", S_REQ_VALID, 64'd0);
      step();
    end
    expect_now("stall_cnt", S_STALL, EXP_STALL);
    exp_inst.push_back(32'hA200_0003);
    exp_pcp4.push_back(64'hC);
    id_ready = 1'b1;
    step();

    // Memory not ready for three cycles
    for (int i = 0; i < 3; i++) begin
      expect_now("busy_req_valid", S_REQ_VALID, 64'd1);
      expect_now("busy_req_addr",  S_REQ_ADDR,  64'hC);
      step();
    end
    xact(64'hC, 32'hB300_0004);

    // Branch while waiting: in-flight response dropped
    exp_req.push_back(64'h10);
    im_req_ready = 1'b1;
    step();
    im_req_ready = 1'b0;
    br_taken     = 1'b1;
    br_target    = 64'h100;
    step();
    br_taken      = 1'b0;
    im_resp_valid = 1'b1;
    im_resp_data  = 32'hDEAD_0005;
    expect_now("squash_wait_inst", S_INST, 64'(NOP_W));
    step();
    im_resp_valid = 1'b0;
    expect_now("squash_inst",     S_INST,      64'(NOP_W));
    expect_now("squash_req_addr", S_REQ_ADDR,  64'h100);
    xact(64'h100, 32'hC400_0006);

    // Branch and decode-ready in the same HOLD cycle
    exp_req.push_back(64'h104);
    im_req_ready = 1'b1;
    id_ready     = 1'b0;
    step();
    im_req_ready  = 1'b0;
    im_resp_valid = 1'b1;
    im_resp_data  = 32'hD500_0007;
    step();
    im_resp_valid = 1'b0;
    id_ready      = 1'b1;
    br_taken      = 1'b1;
    br_target     = 64'h200;
    step();
    br_taken = 1'b0;
    expect_now("brhold_inst",     S_INST,     64'(NOP_W));
    expect_now("brhold_req_addr", S_REQ_ADDR, 64'h200);
    xact(64'h200, 32'hE600_0008);

    // Reset while waiting, then stale responses
    exp_req.push_back(64'h204);
    im_req_ready = 1'b1;
    step();
    im_req_ready = 1'b0;
    reset        = 1'b0;
    expect_now("midrst_req_valid", S_REQ_VALID, 64'd0);
    expect_now("midrst_req_addr",  S_REQ_ADDR,  64'd0);
    expect_now("midrst_inst",      S_INST,      64'(NOP_W));
    expect_now("midrst_pcp4",      S_PCP4,      64'd0);
    expect_now("midrst_stall",     S_STALL,     64'd0);
    step();
    reset         = 1'b1;
    im_resp_valid = 1'b1;
    im_resp_data  = 32'hBAD0_0009;
    expect_now("midrst_release_valid", S_REQ_VALID, 64'd0);
    step();
    expect_now("stale_inst",      S_INST,      64'(NOP_W));
    expect_now("stale_req_valid", S_REQ_VALID, 64'd1);
    expect_now("stale_req_addr",  S_REQ_ADDR,  64'd0);
    step();
    im_resp_valid = 1'b0;
    expect_now("stale_inst2", S_INST, 64'(NOP_W));
    xact(64'h0, 32'hF700_000A);

    // Branch in FETCH to the top of the address space; pc+4 wraps
    br_taken  = 1'b1;
    br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    br_taken = 1'b0;
    expect_now("wrap_req_addr", S_REQ_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
    xact(64'hFFFF_FFFF_FFFF_FFFC, 32'h1800_000B);
    expect_now("wrap_next_addr",  S_REQ_ADDR,  64'd0);
    expect_now("wrap_next_valid", S_REQ_VALID, 64'd1);
    step();

    expect_now("req_queue_drained",  S_REQ_Q,  64'd0);
    expect_now("inst_queue_drained", S_INST_Q, 64'd0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have parameter BUS_DATA_WIDTH, default 64, meaning the PC and address width.
REQ-002 The module SHALL have parameter BUS_INST_WIDTH, default 32, meaning the instruction width.
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 Port clk, input, 1 bit: the only clock; all state is updated on posedge clk.
REQ-005 Port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 Port im_req_valid, output, 1 bit: instruction-memory read request.
REQ-007 Port im_req_addr, output, BUS_DATA_WIDTH bits: request address.
REQ-008 Port im_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-009 Port im_resp_valid, input, 1 bit: the response word is valid this cycle.
REQ-010 Port im_resp_data, input, BUS_INST_WIDTH bits: the fetched instruction.
REQ-011 Port inst, output, BUS_INST_WIDTH bits: instruction presented to decode.
REQ-012 Port IF_PCplus4_out, output, BUS_DATA_WIDTH bits: PC of the presented instruction plus 4.
REQ-013 Port id_ready, input, 1 bit: decode can accept an instruction.
REQ-014 Port br_taken, input, 1 bit, and port br_target, input, BUS_DATA_WIDTH bits: redirect request and its target.
REQ-015 Port stall_cnt, output, 32 bits: decode-stall cycle count (see Configuration).

Function
REQ-016 The FSM SHALL have exactly three states: FETCH, WAIT and HOLD.
REQ-017 In FETCH, im_req_valid=1 and im_req_addr=pc; on im_req_ready=1 the FSM SHALL go to WAIT, otherwise it stays in FETCH.
REQ-018 In WAIT, im_req_valid=0; on im_resp_valid=1 the FSM SHALL capture im_resp_data into an instruction register and go to HOLD.
REQ-019 In HOLD, inst SHALL equal the captured word and IF_PCplus4_out SHALL equal pc+4.
REQ-020 Handoff occurs on a posedge in HOLD with id_ready=1; the FSM SHALL then set pc to pc+4 (modulo 2^BUS_DATA_WIDTH) and go to FETCH.
REQ-021 Outside HOLD, inst SHALL be the NOP constant 32'h01000000 and IF_PCplus4_out SHALL hold its last value.
REQ-022 The minimum latency from request acceptance to inst valid SHALL be 1 cycle after im_resp_valid.
REQ-023 br_taken=1 in FETCH or HOLD SHALL set pc to br_target and force FETCH on the next cycle; any held instruction is discarded.
REQ-024 br_taken=1 in WAIT SHALL set pc to br_target and set a squash flag; the next response SHALL be dropped, with return to FETCH; the squash flag then clears.
REQ-025 br_taken SHALL take priority over a simultaneous handoff or response.
REQ-026 An im_resp_valid pulse outside WAIT SHALL be ignored.

Reset
REQ-027 Asserting reset (low) SHALL asynchronously set state=FETCH, pc=RESET_PC, instruction register=NOP, squash=0, IF_PCplus4_out=0, stall_cnt=0, im_req_valid=0 until the first posedge after deassertion.
REQ-028 Reset mid-operation SHALL abandon any outstanding request; a stale response after reset SHALL be ignored until a new request is accepted.

Configuration
REQ-029 With macro IF_PERF_CNT_EN defined, stall_cnt SHALL increment (saturating at 2^32-1) every cycle with state=HOLD and id_ready=0.
REQ-030 Without IF_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be instantiated.

Structure
REQ-031 The NOP constant, the FSM state enum and default widths SHALL reside in shared package sparc_pkg.
REQ-032 The stall counter SHALL be a sub-module if_stall_counter, instantiated only under IF_PERF_CNT_EN.

Verification
REQ-033 Reset release, memory always ready, response one cycle later with data 32'h82102005, id_ready=1: im_req_addr=0, then inst=32'h82102005 with IF_PCplus4_out=4, then next request addr=4.
REQ-034 id_ready held 0 for 5 cycles in HOLD: inst and IF_PCplus4_out stable, no new request, stall_cnt=5 with the macro and 0 without.
REQ-035 im_req_ready low for 3 cycles: im_req_valid and im_req_addr held, no state advance.
REQ-036 br_taken with br_target=0x100 during WAIT: the in-flight response is dropped, inst remains NOP, next im_req_addr=0x100.
REQ-037 br_taken with id_ready=1 in the same HOLD cycle: no pc+4, next im_req_addr=br_target.
REQ-038 Reset asserted in WAIT, then a response arrives: inst=NOP, next im_req_addr=RESET_PC.
